// File: rtl/snn_syn_mac_if.sv
// Handshake/bus bundle between the synaptic MAC stage and its controller and downstream neuron.
// The master drives start/spikes/weight writes/ready; the slave returns the result and status.
interface snn_syn_mac_if #(
    parameter int N_IN  = 16,
    parameter int W_W   = 8,
    parameter int OUT_W = 8
);
    localparam int AW = $clog2(N_IN);

    logic                    start;
    logic [N_IN-1:0]         spk_in;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic signed [W_W-1:0]   wr_data;
    logic                    mac_ready;
    logic signed [OUT_W-1:0] mac_out;
    logic                    mac_valid;
    logic                    busy;
    logic                    wr_err;

    modport master (
        output start, spk_in, wr_en, wr_addr, wr_data, mac_ready,
        input  mac_out, mac_valid, busy, wr_err
    );

    modport slave (
        input  start, spk_in, wr_en, wr_addr, wr_data, mac_ready,
        output mac_out, mac_valid, busy, wr_err
    );
endinterface

// File: rtl/snn_syn_mac.sv
// Serial synaptic multiply-accumulate: one synapse per clock, signed result handed off via valid/ready.
// Build option SYN_MAC_SAT_EN: saturate the result to OUT_W bits instead of wrapping.
module snn_syn_mac #(
    parameter int N_IN  = 16,
    parameter int W_W   = 8,
    parameter int OUT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    snn_syn_mac_if.slave bus
);
    localparam int AW    = $clog2(N_IN);
    localparam int ACC_W = W_W + AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [AW-1:0] LAST_IDX = AW'(N_IN - 1);

`ifdef SYN_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1'b1);

    function automatic logic signed [OUT_W-1:0] reduce(input logic signed [ACC_W-1:0] a);
        if (a > SAT_MAX) begin
            return OUT_W'(SAT_MAX);
        end else if (a < SAT_MIN) begin
            return OUT_W'(SAT_MIN);
        end else begin
            return OUT_W'(a);
        end
    endfunction
`else
    function automatic logic signed [OUT_W-1:0] reduce(input logic signed [ACC_W-1:0] a);
        return OUT_W'(a);
    endfunction
`endif

    logic [1:0]              state_q, state_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [N_IN-1:0]         snap_q, snap_d;
    logic signed [OUT_W-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    wr_err_q, wr_err_d;
    logic signed [W_W-1:0]   w_q [N_IN];

    logic                    we_s;
    logic signed [W_W-1:0]   w_cur_s;
    logic signed [ACC_W-1:0] term_s;
    logic signed [ACC_W-1:0] acc_sum_s;

    assign we_s      = bus.wr_en && (state_q != ST_ACCUM);
    assign w_cur_s   = w_q[idx_q];
    assign term_s    = snap_q[idx_q] ? {{(ACC_W - W_W){w_cur_s[W_W-1]}}, w_cur_s} : '0;
    assign acc_sum_s = acc_q + term_s;

    // Weight bank: writes land only outside ACCUM; addresses beyond N_IN are discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++) begin
                w_q[i] <= '0;
            end
        end else if (we_s && (int'(bus.wr_addr) < N_IN)) begin
            w_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Next-state logic for the IDLE/ACCUM/HOLD sequencer and its datapath registers.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        snap_d   = snap_q;
        out_d    = out_q;
        valid_d  = valid_q;
        busy_d   = busy_q;
        wr_err_d = bus.wr_en && (state_q == ST_ACCUM);
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ACCUM;
                    snap_d  = bus.spk_in;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_sum_s;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                    out_d   = reduce(acc_sum_s);
                    valid_d = 1'b1;
                end else begin
                    state_d = ST_ACCUM;
                    idx_d   = idx_q + AW'(1'b1);
                end
            end
            ST_HOLD: begin
                if (valid_q && bus.mac_ready) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            snap_q   <= '0;
            out_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            snap_q   <= snap_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign bus.mac_out   = out_q;
    assign bus.mac_valid = valid_q;
    assign bus.busy      = busy_q;
    assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_snn_syn_mac.sv
// Directed bench for snn_syn_mac: table of weight/spike vectors plus hold, write-reject and reset sequences.
module tb_snn_syn_mac;
    localparam int N_IN  = 16;
    localparam int W_W   = 8;
    localparam int OUT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    snn_syn_mac_if #(.N_IN(N_IN), .W_W(W_W), .OUT_W(OUT_W)) bus ();

    snn_syn_mac #(.N_IN(N_IN), .W_W(W_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        int         mode;
        logic [15:0] spk;
        logic [7:0] exp_wrap;
        logic [7:0] exp_sat;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // mode 0: w[i]=i, 1: all 20, 2: all -100, 3: +100 on even / -100 on odd
    function automatic logic [7:0] wval(input int mode, input int i);
        case (mode)
            0:       return 8'(i);
            1:       return 8'd20;
            2:       return 8'h9C;
            3:       return (i % 2 == 0) ? 8'd100 : 8'h9C;
            default: return 8'h00;
        endcase
    endfunction

    task automatic load(input int mode);
        for (int i = 0; i < N_IN; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = 4'(i);
            bus.wr_data = wval(mode, i);
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_valid(input int already, output int lat);
        lat = already;
        while (!bus.mac_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic start_run(input logic [15:0] spk);
        bus.start  = 1'b1;
        bus.spk_in = spk;
        tick();
        bus.start  = 1'b0;
        bus.spk_in = ~spk;
    endtask

    function automatic logic [7:0] pick(input vec_t v);
`ifdef SYN_MAC_SAT_EN
        return v.exp_sat;
`else
        return v.exp_wrap;
`endif
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [7:0] e;

        vecs[0]  = '{0, 16'h000F, 8'h06, 8'h06};
        vecs[1]  = '{0, 16'h8000, 8'h0F, 8'h0F};
        vecs[2]  = '{0, 16'hFFFF, 8'h78, 8'h78};
        vecs[3]  = '{0, 16'h0000, 8'h00, 8'h00};
        vecs[4]  = '{1, 16'hFFFF, 8'h40, 8'h7F};
        vecs[5]  = '{2, 16'h0003, 8'h38, 8'h80};
        vecs[6]  = '{2, 16'h0001, 8'h9C, 8'h9C};
        vecs[7]  = '{2, 16'hFFFF, 8'hC0, 8'h80};
        vecs[8]  = '{3, 16'hFFFF, 8'h00, 8'h00};
        vecs[9]  = '{3, 16'h0005, 8'hC8, 8'h7F};
        vecs[10] = '{3, 16'h0007, 8'h64, 8'h64};

        bus.start     = 1'b0;
        bus.spk_in    = '0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.mac_ready = 1'b1;
        tick();
        tick();
        chk("reset_mac_out", {24'h0, bus.mac_out}, 32'h0);
        chk("reset_valid", {31'h0, bus.mac_valid}, 32'h0);
        chk("reset_busy", {31'h0, bus.busy}, 32'h0);
        chk("reset_wr_err", {31'h0, bus.wr_err}, 32'h0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 11; v++) begin
            load(vecs[v].mode);
            start_run(vecs[v].spk);
            chk($sformatf("vec%0d_busy", v), {31'h0, bus.busy}, 32'h1);
            wait_valid(0, lat);
            e = pick(vecs[v]);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd16);
            chk($sformatf("vec%0d_mac_out", v), {24'h0, bus.mac_out}, {24'h0, e});
            tick();
            chk($sformatf("vec%0d_valid_one_cycle", v), {30'h0, bus.mac_valid, bus.busy}, 32'h0);
        end

        // HOLD with ready low: output stable, start ignored, write to w[0] lands
        load(0);
        bus.mac_ready = 1'b0;
        start_run(16'h0003);
        wait_valid(0, lat);
        chk("hold_latency", 32'(lat), 32'd16);
        for (int c = 0; c < 5; c++) begin
            bus.start   = 1'b1;
            bus.wr_en   = (c == 0);
            bus.wr_addr = 4'd0;
            bus.wr_data = 8'd50;
            tick();
            bus.wr_en = 1'b0;
            chk($sformatf("hold_stable_c%0d", c), {23'h0, bus.mac_valid, bus.mac_out}, {23'h0, 1'b1, 8'h01});
        end
        bus.mac_ready = 1'b1;
        tick();
        chk("hold_accept_idle", {30'h0, bus.mac_valid, bus.busy}, 32'h0);
        bus.start = 1'b0;
        tick();
        chk("hold_start_not_queued", {31'h0, bus.busy}, 32'h0);
        chk("hold_out_kept", {24'h0, bus.mac_out}, 32'h01);
        start_run(16'h0003);
        wait_valid(0, lat);
        chk("hold_new_w0", {24'h0, bus.mac_out}, 32'd51);
        tick();

        // write during ACCUM is rejected with a one-cycle error pulse
        load(0);
        start_run(16'hFFFF);
        tick();
        tick();
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd5;
        bus.wr_data = 8'd99;
        tick();
        bus.wr_en = 1'b0;
        chk("wr_err_pulse", {31'h0, bus.wr_err}, 32'h1);
        tick();
        chk("wr_err_clear", {31'h0, bus.wr_err}, 32'h0);
        wait_valid(4, lat);
        chk("wr_err_latency", 32'(lat), 32'd16);
        chk("wr_err_result", {24'h0, bus.mac_out}, 32'h78);
        tick();
        start_run(16'h0020);
        wait_valid(0, lat);
        chk("wr_err_w5_kept", {24'h0, bus.mac_out}, 32'h05);
        tick();

        // reset mid-ACCUM at idx 7 clears everything including weights
        load(1);
        start_run(16'hFFFF);
        for (int c = 0; c < 7; c++) begin
            tick();
        end
        chk("pre_rst_busy", {31'h0, bus.busy}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_mid_valid", {31'h0, bus.mac_valid}, 32'h0);
        chk("rst_mid_out", {24'h0, bus.mac_out}, 32'h0);
        start_run(16'hFFFF);
        wait_valid(0, lat);
        chk("rst_fresh_latency", 32'(lat), 32'd16);
        chk("rst_weights_zero", {24'h0, bus.mac_out}, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
